// File: rtl/cdc_sync_multi.sv
// Multi-channel level synchronizer into the clk_out domain with an optional
// stability filter, level/toggle event pulses and sticky event flags.
module cdc_sync_multi #(
  parameter int unsigned          CHANNELS    = 4,
  parameter int unsigned          STAGES      = 2,
  parameter int unsigned          FILT_CYCLES = 0,
  parameter logic [CHANNELS-1:0]  RESET_VAL   = {CHANNELS{1'b0}}
) (
  input  logic                clk_out,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] async_in,
  input  logic [CHANNELS-1:0] toggle_mode,
  input  logic [CHANNELS-1:0] evt_clr,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] evt_sticky
);

  localparam int unsigned CNT_W = (FILT_CYCLES > 0) ? $clog2(FILT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES);

  if (STAGES < 2) begin : g_stages_check
    $error("cdc_sync_multi: STAGES must be >= 2");
  end

  logic [STAGES-1:0][CHANNELS-1:0] chain_q, chain_d;
  logic [CHANNELS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [CHANNELS-1:0]             level_q, level_d;
  logic [CHANNELS-1:0]             rise_q, rise_d;
  logic [CHANNELS-1:0]             fall_q, fall_d;
  logic [CHANNELS-1:0]             sticky_q, sticky_d;
  logic [CHANNELS-1:0]             sync_s;
  logic [CHANNELS-1:0]             change_s;

  assign chain_d = {chain_q[STAGES-2:0], async_in};
  assign sync_s  = chain_q[STAGES-1];

  // Stability filter: level_q only moves after FILT_CYCLES+1 consecutive differing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sync_s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = sync_s[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Pulses are computed from the upcoming level change so they appear with the new level.
  always_comb begin
    change_s = level_d ^ level_q;
    rise_d   = change_s & (toggle_mode | level_d);
    fall_d   = change_s & ~toggle_mode & ~level_d;
    sticky_d = (sticky_q & ~evt_clr) | rise_q | fall_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_out) begin
    if (!rst_n) begin
      chain_q  <= {STAGES{RESET_VAL}};
      cnt_q    <= '0;
      level_q  <= RESET_VAL;
      rise_q   <= '0;
      fall_q   <= '0;
      sticky_q <= '0;
    end else begin
      chain_q  <= chain_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sticky_q <= sticky_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign evt_sticky = sticky_q;

endmodule

// File: tb/tb_cdc_sync_multi.sv
// Self-checking bench for cdc_sync_multi: three parameterisations share one
// stimulus; a window-based reference model plus directed tables and sequences.
module tb_cdc_sync_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] async_in, toggle_mode, evt_clr;
  logic [3:0] d_lvl [3];
  logic [3:0] d_rise [3];
  logic [3:0] d_fall [3];
  logic [3:0] d_stk [3];

  always #5 clk = ~clk;

  // instance 0: S=2 F=0 R=0101; instance 1: S=3 F=0 R=0; instance 2: S=2 F=3 R=0
  cdc_sync_multi #(.CHANNELS(4), .STAGES(2), .FILT_CYCLES(0), .RESET_VAL(4'b0101)) u_a (
    .clk_out(clk), .rst_n(rst_n), .async_in(async_in), .toggle_mode(toggle_mode),
    .evt_clr(evt_clr), .level_out(d_lvl[0]), .rise_pulse(d_rise[0]),
    .fall_pulse(d_fall[0]), .evt_sticky(d_stk[0]));
  cdc_sync_multi #(.CHANNELS(4), .STAGES(3), .FILT_CYCLES(0), .RESET_VAL(4'b0000)) u_b (
    .clk_out(clk), .rst_n(rst_n), .async_in(async_in), .toggle_mode(toggle_mode),
    .evt_clr(evt_clr), .level_out(d_lvl[1]), .rise_pulse(d_rise[1]),
    .fall_pulse(d_fall[1]), .evt_sticky(d_stk[1]));
  cdc_sync_multi #(.CHANNELS(4), .STAGES(2), .FILT_CYCLES(3), .RESET_VAL(4'b0000)) u_c (
    .clk_out(clk), .rst_n(rst_n), .async_in(async_in), .toggle_mode(toggle_mode),
    .evt_clr(evt_clr), .level_out(d_lvl[2]), .rise_pulse(d_rise[2]),
    .fall_pulse(d_fall[2]), .evt_sticky(d_stk[2]));

  int         S [3] = '{2, 3, 2};
  int         F [3] = '{0, 0, 3};
  logic [3:0] R [3] = '{4'b0101, 4'b0000, 4'b0000};

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [3:0] in_log [0:4095];
  int         n_edge = 0;
  logic [3:0] m_lvl [3];
  logic [3:0] m_rise [3];
  logic [3:0] m_fall [3];
  logic [3:0] m_stk [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // synchronized value visible just before post-reset edge m
  function automatic logic [3:0] sv_at(int k, int m);
    if (m - S[k] >= 0) return in_log[m - S[k]];
    else return R[k];
  endfunction

  // Level flips once the last F+1 visible synced samples all disagree with it.
  task automatic model_step();
    logic [3:0] nl, sv;
    bit         diff_all;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_lvl[k] = R[k]; m_rise[k] = 4'b0; m_fall[k] = 4'b0; m_stk[k] = 4'b0;
      end else begin
        m_stk[k] = (m_stk[k] & ~evt_clr) | m_rise[k] | m_fall[k];
        nl = m_lvl[k];
        for (int c = 0; c < 4; c++) begin
          diff_all = (n_edge >= F[k]);
          for (int m = n_edge - F[k]; m <= n_edge; m++) begin
            if (m >= 0) begin
              sv = sv_at(k, m);
              if (sv[c] == m_lvl[k][c]) diff_all = 1'b0;
            end
          end
          if (diff_all) nl[c] = ~m_lvl[k][c];
        end
        m_rise[k] = (nl ^ m_lvl[k]) & (toggle_mode | nl);
        m_fall[k] = (nl ^ m_lvl[k]) & ~toggle_mode & ~nl;
        m_lvl[k]  = nl;
      end
    end
    if (!rst_n) begin
      n_edge = 0;
    end else begin
      if (n_edge < 4096) in_log[n_edge] = async_in;
      n_edge++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_lvl%0d", k),  d_lvl[k],  m_lvl[k]);
      chk($sformatf("model_rise%0d", k), d_rise[k], m_rise[k]);
      chk($sformatf("model_fall%0d", k), d_fall[k], m_fall[k]);
      chk($sformatf("model_stk%0d", k),  d_stk[k],  m_stk[k]);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] ain;
    logic [3:0] clr;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] stk;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int rc, fc;
    bit seen;
    rst_n = 1'b0; async_in = 4'b0101; toggle_mode = 4'b0000; evt_clr = 4'b0000;

    // reset defaults, level rise/fall pulses, sticky set and clear on instance 0
    tbl[0]  = '{1'b0, 4'b0101, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b0, 4'b0101, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{1'b0, 4'b0101, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0000};
    tbl[3]  = '{1'b1, 4'b0101, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0000};
    tbl[4]  = '{1'b1, 4'b0111, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0000};
    tbl[5]  = '{1'b1, 4'b0111, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0000};
    tbl[6]  = '{1'b1, 4'b0111, 4'b0000, 4'b0111, 4'b0010, 4'b0000, 4'b0000};
    tbl[7]  = '{1'b1, 4'b0110, 4'b0000, 4'b0111, 4'b0000, 4'b0000, 4'b0010};
    tbl[8]  = '{1'b1, 4'b0110, 4'b0000, 4'b0111, 4'b0000, 4'b0000, 4'b0010};
    tbl[9]  = '{1'b1, 4'b0110, 4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0000};
    tbl[10] = '{1'b1, 4'b0110, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0001};
    for (int i = 0; i < 11; i++) begin
      rst_n = tbl[i].rst; async_in = tbl[i].ain; evt_clr = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d_lvl", i),  d_lvl[0],  tbl[i].lvl);
      chk($sformatf("tbl%0d_rise", i), d_rise[0], tbl[i].rise);
      chk($sformatf("tbl%0d_fall", i), d_fall[0], tbl[i].fall);
      chk($sformatf("tbl%0d_stk", i),  d_stk[0],  tbl[i].stk);
    end
    evt_clr = 4'b0000;

    // latency with STAGES=3: level and pulse at edge 4, sticky from edge 5
    rst_n = 1'b0; async_in = 4'b0000;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    async_in[0] = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("lat_lvl_e%0d", e),  d_lvl[1][0],  (e >= 4));
      chk($sformatf("lat_rise_e%0d", e), d_rise[1][0], (e == 4));
      chk($sformatf("lat_stk_e%0d", e),  d_stk[1][0],  (e >= 5));
    end

    // filter FILT_CYCLES=3: 3-cycle glitch is swallowed
    async_in[1] = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      if (e == 4) async_in[1] = 1'b0;
      tick();
      chk("filt_glitch_lvl", d_lvl[2][1], 1'b0);
      chk("filt_glitch_rise", d_rise[2][1], 1'b0);
    end
    async_in[1] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk($sformatf("filt_hi_lvl_e%0d", e),  d_lvl[2][1],  (e >= 6));
      chk($sformatf("filt_hi_rise_e%0d", e), d_rise[2][1], (e == 6));
    end
    async_in[1] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("filt_lo_lvl_e%0d", e),  d_lvl[2][1],  (e < 6));
      chk($sformatf("filt_lo_fall_e%0d", e), d_fall[2][1], (e == 6));
    end

    // toggle mode on ch2: two rise pulses, no fall pulse
    toggle_mode = 4'b0100; rc = 0; fc = 0;
    async_in[2] = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      if (e == 9) async_in[2] = 1'b0;
      tick();
      rc += int'(d_rise[0][2]);
      fc += int'(d_fall[0][2]);
    end
    chk("toggle_rise_count", rc, 2);
    chk("toggle_fall_count", fc, 0);
    toggle_mode = 4'b0000;

    // sticky set/clear race on ch3: set wins, next clear takes effect
    async_in[3] = 1'b1; seen = 1'b0;
    for (int e = 0; e < 10 && !seen; e++) begin
      tick();
      seen = d_rise[0][3];
    end
    chk("race_rise_seen", seen, 1'b1);
    evt_clr = 4'b1000;
    tick();
    chk("race_set_wins", d_stk[0][3], 1'b1);
    tick();
    chk("race_clear", d_stk[0][3], 1'b0);
    evt_clr = 4'b0000;

    // reset mid-flight, input reverted: level stays at reset value, no pulse
    async_in[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    async_in[0] = 1'b1; rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("mid_revert_lvl", d_lvl[0][0], 1'b1);
      chk("mid_revert_fall", d_fall[0][0], 1'b0);
    end
    // reset mid-flight, input kept: exactly one fall pulse after release
    async_in[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; fc = 0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      fc += int'(d_fall[0][0]);
    end
    chk("mid_kept_fall_count", fc, 1);
    chk("mid_kept_lvl", d_lvl[0][0], 1'b0);

    // randomized stimulus against the reference model
    for (int t = 0; t < 400; t++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(3) == 0) async_in[c] = ~async_in[c];
      end
      evt_clr = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
      if (t % 40 == 0) toggle_mode = 4'($urandom);
      rst_n = ($urandom_range(99) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
